layer1_pipeline_feeder: RTL and testbench
=========================================

// Module: layer1_pipeline_feeder
// PURPOSE
//  Producer/sequencer for the layer-1 adder+bias+ReLU pipeline (pipeline_layer1).
//  - Aligns three independently arriving FP32 channel partial sums (R,G,B conv results).
//  - Issues each aligned triple as one 96-bit word and drives the pipeline stage enables.
//  - Captures the returned ReLU output and tags it with its output-pixel (col,row) position.
// PARAMETERS
//  DATA_WIDTH  32   word width; fixed FP32
//  FIFO_DEPTH  4    entries per channel FIFO; power of 2, >=2
//  IMG_W       224  output-map width in pixels
//  IMG_H       224  output-map height in pixels
// PORTS
//  clk             in   1    clock
//  rst             in   1    synchronous, active-low reset
//  ch_data0/1/2    in   32   channel 0/1/2 partial sums, FP32
//  ch_valid        in   3    per-channel valid; bit k goes with ch_datak
//  ch_ready        out  3    per-channel ready; bit k = FIFO k not full
//  o_pipe_data     out  96   {ch2,ch1,ch0}; ch0 in [31:0], to pipeline input
//  o_valid_in_bias out  1    stage-1 enable to pipeline
//  o_valid_pipe    out  2    stage-2/3 enables to pipeline
//  i_result        in   32   pipeline ReLU output
//  o_result        out  32   captured result
//  o_result_valid  out  1    1-cycle strobe; o_result/o_col/o_row valid
//  o_col           out  $clog2(IMG_W)  column of o_result
//  o_row           out  $clog2(IMG_H)  row of o_result
//  o_frame_done    out  1    pulses with the last pixel of a frame
// BEHAVIOUR
//  Reset (rst==0 at a clk edge):
//  - Outputs: all FIFOs empty, ch_ready=3'b111 on the next cycle, and every other output 0.
//  - Issue shift register cleared; in-flight results are discarded, never reported.
//  Channel FIFOs:
//  - Push k when ch_valid[k]&&ch_ready[k]. ch_ready[k] = !full_k, combinational from count.
//  - Full: no push. Empty: no pop. Push and pop in the same cycle: count unchanged.
//  - Pointers wrap modulo FIFO_DEPTH.
//  Issue:
//  - Condition: all three FIFOs non-empty at edge t. Pop all three together.
//  - o_pipe_data is registered and o_valid_in_bias=1 during cycle t+1 (one-cycle pulse).
//  - Channels are never issued individually. Maximum rate is 1 issue per cycle.
//  Stage enables:
//  - A 3-bit shift register vs tracks issues; vs[1]=o_valid_in_bias delayed one cycle.
//  - o_valid_pipe[0]=vs[1], o_valid_pipe[1]=vs[2].
//  - Back-to-back issues give continuous enables. Gaps give zeros; the pipeline holds its registers.
//  Capture:
//  - When vs[3]=1, o_result<=i_result and o_result_valid=1 the next cycle.
//  - Latency from o_valid_in_bias high to o_result_valid high is 4 cycles.
//  - Order of results = issue order. No backpressure on results.
//  Position counters:
//  - Advance after each o_result_valid.
//  - col wraps at IMG_W-1 and increments row; row wraps at IMG_H-1 to 0.
//  - o_frame_done=1 with the strobe whose col=IMG_W-1 and row=IMG_H-1; counters are 0 afterwards.
//  Arithmetic:
//  - No FP arithmetic here; data passes bit-exact.
//  - Counters are unsigned, widths from $clog2.
// STRUCTURE
//  - Shared include vgg16_params.vh: DATA_WIDTH, layer-1 IMG_W/IMG_H, the pipeline latency
//    constant (3), and FP32 constants (bias 2.0=32'h40000000).
//  - One sub-module: layer1_ch_fifo (sync FIFO, DEPTH param, data/valid/ready in, pop/empty out), instanced 3x.
//  - Top holds the issue logic, the vs shift register, capture and position counters.
// TESTING (bench: this block + pipeline_layer1 with bias 2.0, reset-polarity adapted)
//  1. ch0/1/2=1.0 (3F800000) same cycle
//     -> o_valid_in_bias 1 cycle later; o_result=40A00000 (5.0), o_result_valid 4 cycles after issue.
//  2. ch0=-8.0 (C1000000), ch1=1.0, ch2=1.0
//     -> ReLU gives o_result=0; col increments to 1.
//  3. Staggered arrival: ch0 at t0, ch1 at t0+3, ch2 at t0+7
//     -> single issue at t0+8; no issue before it.
//  4. Fill ch0 with 4 words while ch1/ch2 idle
//     -> ch_ready[0]=0 after 4th push; 5th word held; after ch1/ch2 supply one word each, a pop
//        occurs and ch_ready[0] returns to 1.
//  5. 6 back-to-back triples
//     -> o_valid_pipe continuous; 6 consecutive o_result_valid strobes in order.
//  6. IMG_W=4, IMG_H=2: stream 8 results
//     -> o_frame_done on the 8th (col=3,row=1), next at col=0,row=0.
//     Assert rst mid-stream with 2 in flight -> neither reported, ch_ready=111.

Source files
------------

// File: rtl/layer1_pipeline_feeder_pkg.sv
// Shared constants for the layer-1 feeder: data width, output-map geometry,
// downstream pipeline depth and the FP32 constants the pipeline uses.
package layer1_pipeline_feeder_pkg;

  localparam int L1_DATA_WIDTH = 32;
  localparam int L1_FIFO_DEPTH = 4;
  localparam int L1_IMG_W      = 224;
  localparam int L1_IMG_H      = 224;
  localparam int NUM_CH        = 3;

  // Register stages in pipeline_layer1 between the data word and the ReLU output.
  localparam int PIPE_STAGES   = 3;

  localparam logic [31:0] FP32_ONE  = 32'h3F80_0000;
  localparam logic [31:0] FP32_BIAS = 32'h4000_0000;

endpackage

// File: rtl/layer1_ch_fifo.sv
// Per-channel synchronous FIFO: ready while not full, head word visible on data_o
// whenever not empty; pop removes the head. Pointers wrap modulo DEPTH (power of 2).
module layer1_ch_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] data_i,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic          pop_i,
  output logic          empty_o,
  output logic [DW-1:0] data_o
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  logic [DW-1:0]   mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            push, pop;

  assign ready_o = (count_q != CNTW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push    = valid_i && ready_o;
  assign pop     = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) count_d = count_q + CNTW'(1);
    if (pop && !push) count_d = count_q - CNTW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/layer1_pipeline_feeder.sv
// Aligns three channel partial sums, issues them as one word to pipeline_layer1,
// drives its stage enables and tags each returned ReLU result with its (col,row).
module layer1_pipeline_feeder
  import layer1_pipeline_feeder_pkg::*;
#(
  parameter int  DATA_WIDTH = L1_DATA_WIDTH,
  parameter int  FIFO_DEPTH = L1_FIFO_DEPTH,
  parameter int  IMG_W      = L1_IMG_W,
  parameter int  IMG_H      = L1_IMG_H,
  localparam int CW         = $clog2(IMG_W),
  localparam int RW         = $clog2(IMG_H)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   ch_data0,
  input  logic [DATA_WIDTH-1:0]   ch_data1,
  input  logic [DATA_WIDTH-1:0]   ch_data2,
  input  logic [2:0]              ch_valid,
  output logic [2:0]              ch_ready,
  output logic [3*DATA_WIDTH-1:0] o_pipe_data,
  output logic                    o_valid_in_bias,
  output logic [1:0]              o_valid_pipe,
  input  logic [DATA_WIDTH-1:0]   i_result,
  output logic [DATA_WIDTH-1:0]   o_result,
  output logic                    o_result_valid,
  output logic [CW-1:0]           o_col,
  output logic [RW-1:0]           o_row,
  output logic                    o_frame_done
);

  logic [DATA_WIDTH-1:0] ch_data  [NUM_CH];
  logic [DATA_WIDTH-1:0] head_dat [NUM_CH];
  logic [NUM_CH-1:0]     empty;
  logic                  issue;

  assign ch_data[0] = ch_data0;
  assign ch_data[1] = ch_data1;
  assign ch_data[2] = ch_data2;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    layer1_ch_fifo #(
      .DW   (DATA_WIDTH),
      .DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .data_i (ch_data[k]),
      .valid_i(ch_valid[k]),
      .ready_o(ch_ready[k]),
      .pop_i  (issue),
      .empty_o(empty[k]),
      .data_o (head_dat[k])
    );
  end

  // A triple leaves only when every channel has its partial sum queued.
  assign issue = ~|empty;

  logic [3*DATA_WIDTH-1:0] pipe_data_q, pipe_data_d;
  logic                    vib_q, vib_d;
  logic [PIPE_STAGES:1]    vs_q, vs_d;
  logic [DATA_WIDTH-1:0]   result_q, result_d;
  logic                    res_vld_q, res_vld_d;
  logic [CW-1:0]           col_q, col_d;
  logic [RW-1:0]           row_q, row_d;
  logic                    last_col, last_row;

  assign last_col = (col_q == CW'(IMG_W - 1));
  assign last_row = (row_q == RW'(IMG_H - 1));

  always_comb begin
    pipe_data_d = issue ? {head_dat[2], head_dat[1], head_dat[0]} : pipe_data_q;
    vib_d       = issue;
    vs_d        = {vs_q[PIPE_STAGES-1:1], vib_q};
    res_vld_d   = vs_q[PIPE_STAGES];
    result_d    = vs_q[PIPE_STAGES] ? i_result : result_q;
    col_d       = col_q;
    row_d       = row_q;
    // Position of the strobe just reported advances to the next pixel, raster order.
    if (res_vld_q) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pipe_data_q <= '0;
      vib_q       <= 1'b0;
      vs_q        <= '0;
      result_q    <= '0;
      res_vld_q   <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
    end else begin
      pipe_data_q <= pipe_data_d;
      vib_q       <= vib_d;
      vs_q        <= vs_d;
      result_q    <= result_d;
      res_vld_q   <= res_vld_d;
      col_q       <= col_d;
      row_q       <= row_d;
    end
  end

  assign o_pipe_data     = pipe_data_q;
  assign o_valid_in_bias = vib_q;
  assign o_valid_pipe    = vs_q[2:1];
  assign o_result        = result_q;
  assign o_result_valid  = res_vld_q;
  assign o_col           = col_q;
  assign o_row           = row_q;
  assign o_frame_done    = res_vld_q && last_col && last_row;

endmodule

// File: tb/tb_layer1_pipeline_feeder.sv
// Feeder plus a behavioural pipeline_layer1 (sum + 2.0, ReLU) under randomized
// valid/ready traffic, checked every cycle against a queue/event-table model.
module tb_layer1_pipeline_feeder;

  localparam int DEPTH = 4;
  localparam int W     = 4;
  localparam int H     = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] ch_data0 = '0, ch_data1 = '0, ch_data2 = '0;
  logic [2:0]  ch_valid = '0;
  logic [2:0]  ch_ready;
  logic [95:0] o_pipe_data;
  logic        o_valid_in_bias;
  logic [1:0]  o_valid_pipe;
  logic [31:0] i_result;
  logic [31:0] o_result;
  logic        o_result_valid;
  logic [1:0]  o_col;
  logic [0:0]  o_row;
  logic        o_frame_done;

  always #5 clk = ~clk;

  layer1_pipeline_feeder #(
    .DATA_WIDTH(32), .FIFO_DEPTH(DEPTH), .IMG_W(W), .IMG_H(H)
  ) dut (
    .clk(clk), .rst(rst),
    .ch_data0(ch_data0), .ch_data1(ch_data1), .ch_data2(ch_data2),
    .ch_valid(ch_valid), .ch_ready(ch_ready),
    .o_pipe_data(o_pipe_data), .o_valid_in_bias(o_valid_in_bias),
    .o_valid_pipe(o_valid_pipe), .i_result(i_result),
    .o_result(o_result), .o_result_valid(o_result_valid),
    .o_col(o_col), .o_row(o_row), .o_frame_done(o_frame_done)
  );

  // ---------------- FP32 helpers (integer-valued operands only) ----------------
  function automatic real f2r(input logic [31:0] b);
    real m;
    int  e;
    if (b[30:0] == 31'd0) return 0.0;
    e = int'(b[30:23]) - 127;
    m = 1.0 + real'(b[22:0]) / 8388608.0;
    if (e > 0) for (int i = 0; i < e; i++) m = m * 2.0;
    else       for (int i = 0; i < -e; i++) m = m / 2.0;
    return b[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(input real v);
    logic        s;
    longint      mag;
    int          msb;
    logic [31:0] r;
    s   = (v < 0.0);
    mag = s ? longint'(-v) : longint'(v);
    if (mag == 0) return 32'h0;
    msb = 0;
    for (int i = 0; i < 40; i++) if (mag[i]) msb = i;
    r[31]    = s;
    r[30:23] = 8'(127 + msb);
    r[22:0]  = 23'(mag << (23 - msb));
    return r;
  endfunction

  // pipeline_layer1 function: ReLU(ch0 + ch1 + ch2 + bias 2.0)
  function automatic logic [31:0] pipe_fn(input logic [95:0] d);
    real s;
    s = f2r(d[31:0]) + f2r(d[63:32]) + f2r(d[95:64]) + 2.0;
    if (s < 0.0) s = 0.0;
    return r2f(s);
  endfunction

  function automatic logic [31:0] rnd_word();
    int v;
    v = int'($urandom_range(40)) - 20;
    return r2f(real'(v));
  endfunction

  // ---------------- behavioural pipeline_layer1 ----------------
  logic [31:0] s1 = '0, s2 = '0, s3 = '0;
  always @(posedge clk) begin
    if (o_valid_in_bias) s1 <= pipe_fn(o_pipe_data);
    if (o_valid_pipe[0]) s2 <= s1;
    if (o_valid_pipe[1]) s3 <= s2;
  end
  assign i_result = s3;

  // ---------------- reference model state ----------------
  int          tests = 0, fails = 0;
  int          cyc = 0, last_reset = 0;
  bit          issue_at [8192];
  logic [95:0] issue_dat[8192];
  logic [31:0] mq[3][$];
  logic [2:0]  pending = '0;
  logic [31:0] pdata[3];
  int          mcol = 0, mrow = 0;
  int          vib_count = 0, vib_cyc = 0, rv_count = 0, rv_cyc = 0, fd_count = 0;
  int          run = 0, max_run = 0;
  logic [31:0] last_res = '0;
  int          last_col = 0, last_row = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // An issue made at edge m is still in flight only if no reset edge followed it.
  function automatic bit live(input int m);
    return (m > 0) && (m > last_reset) && issue_at[m];
  endfunction

  task automatic model_step();
    logic [2:0] rdy;
    bit         iss;
    cyc++;
    if (cyc >= 8190) begin
      $display("FAIL cycle_budget: got %0d expected below 8190", cyc);
      $fatal(1, "cycle budget exhausted");
    end
    if (!rst) begin
      for (int k = 0; k < 3; k++) mq[k].delete();
      last_reset    = cyc;
      issue_at[cyc] = 1'b0;
      mcol = 0;
      mrow = 0;
    end else begin
      for (int k = 0; k < 3; k++) rdy[k] = (mq[k].size() < DEPTH);
      iss = (mq[0].size() > 0) && (mq[1].size() > 0) && (mq[2].size() > 0);
      issue_at[cyc] = iss;
      if (iss) issue_dat[cyc] = {mq[2].pop_front(), mq[1].pop_front(), mq[0].pop_front()};
      for (int k = 0; k < 3; k++) begin
        if (ch_valid[k] && rdy[k]) begin
          mq[k].push_back(pdata[k]);
          pending[k] = 1'b0;
        end
      end
    end
  endtask

  task automatic compare();
    logic [2:0] erdy;
    logic [1:0] evp;
    bit         erv, efd;
    int         n;
    n = cyc;
    for (int k = 0; k < 3; k++) erdy[k] = (mq[k].size() < DEPTH);
    chk("ch_ready", 96'(ch_ready), 96'(erdy));
    chk("valid_in_bias", 96'(o_valid_in_bias), 96'(issue_at[n]));
    if (issue_at[n] && o_valid_in_bias) chk("pipe_data", o_pipe_data, issue_dat[n]);
    evp = {live(n - 2), live(n - 1)};
    chk("valid_pipe", 96'(o_valid_pipe), 96'(evp));
    erv = live(n - 4);
    chk("result_valid", 96'(o_result_valid), 96'(erv));
    efd = 1'b0;
    if (erv) begin
      chk("result", 96'(o_result), 96'(pipe_fn(issue_dat[n - 4])));
      chk("col", 96'(o_col), 96'(mcol));
      chk("row", 96'(o_row), 96'(mrow));
      efd = (mcol == W - 1) && (mrow == H - 1);
      if (mcol == W - 1) begin
        mcol = 0;
        mrow = (mrow == H - 1) ? 0 : mrow + 1;
      end else begin
        mcol++;
      end
    end
    chk("frame_done", 96'(o_frame_done), 96'(efd));
    if (n == last_reset) begin
      chk("reset_pipe_data", o_pipe_data, 96'h0);
      chk("reset_result_pos", 96'({o_result, o_col, o_row}), 96'h0);
    end
    if (o_valid_in_bias) begin vib_count++; vib_cyc = n; end
    if (o_frame_done) fd_count++;
    if (o_result_valid) begin
      rv_count++;
      rv_cyc   = n;
      last_res = o_result;
      last_col = int'(o_col);
      last_row = int'(o_row);
      run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
  endtask

  task automatic tick();
    ch_valid = pending;
    ch_data0 = pdata[0];
    ch_data1 = pdata[1];
    ch_data2 = pdata[2];
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic put(input int k, input logic [31:0] v);
    pending[k] = 1'b1;
    pdata[k]   = v;
  endtask

  task automatic do_reset(input int n);
    rst     = 1'b0;
    pending = '0;
    repeat (n) tick();
    rst = 1'b1;
    chk("reset_ready", 96'(ch_ready), 96'(3'b111));
    tick();
  endtask

  task automatic drain_pending(input string name, input int bound);
    int g;
    g = 0;
    while (pending != 3'b000 && g < bound) begin tick(); g++; end
    chk(name, 96'(pending), 96'h0);
  endtask

  task automatic wait_rv(input string name, input int bound);
    int start, g;
    start = rv_count;
    g = 0;
    while (rv_count == start && g < bound) begin tick(); g++; end
    chk(name, 96'(rv_count - start), 96'h1);
  endtask

  task automatic feed_triples(input int n);
    int sent[3];
    int g;
    sent = '{0, 0, 0};
    g = 0;
    while ((sent[0] < n || sent[1] < n || sent[2] < n || pending != 3'b000) && g < 10 * n + 20) begin
      for (int k = 0; k < 3; k++) begin
        if (!pending[k] && sent[k] < n) begin
          put(k, rnd_word());
          sent[k]++;
        end
      end
      tick();
      g++;
    end
    chk("feed_timeout", 96'(pending), 96'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish within 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, start;
    int pct[3];
    for (int k = 0; k < 3; k++) pdata[k] = '0;

    // Model pins: 1+1+1+2 = 5.0, and -8+1+1+2 clipped to 0 by ReLU
    chk("pin_sum5", 96'(pipe_fn({32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000})), 96'h40A0_0000);
    chk("pin_relu0", 96'(pipe_fn({32'h3F80_0000, 32'h3F80_0000, 32'hC100_0000})), 96'h0);

    do_reset(3);

    // 1: three 1.0 words together
    put(0, 32'h3F80_0000); put(1, 32'h3F80_0000); put(2, 32'h3F80_0000);
    drain_pending("t1_accept", 5);
    wait_rv("t1_wait", 12);
    chk("t1_result", 96'(last_res), 96'h40A0_0000);
    chk("t1_latency", 96'(rv_cyc - vib_cyc), 96'd4);

    // 2: negative sum clipped; second pixel of the row
    put(0, 32'hC100_0000); put(1, 32'h3F80_0000); put(2, 32'h3F80_0000);
    drain_pending("t2_accept", 5);
    wait_rv("t2_wait", 12);
    chk("t2_result", 96'(last_res), 96'h0);
    chk("t2_col", 96'(last_col), 96'd1);

    // 3: staggered arrival, exactly one issue one edge after the last channel lands
    repeat (4) tick();
    start = vib_count;
    t0    = cyc + 1;
    put(0, rnd_word());
    repeat (3) tick();
    put(1, rnd_word());
    repeat (4) tick();
    put(2, rnd_word());
    repeat (12) tick();
    chk("t3_issue_count", 96'(vib_count - start), 96'd1);
    chk("t3_issue_cycle", 96'(vib_cyc - t0), 96'd8);

    // 4: fill ch0 alone
    for (int i = 0; i < 4; i++) begin put(0, rnd_word()); tick(); end
    chk("t4_full_ready0", 96'(ch_ready[0]), 96'h0);
    put(0, rnd_word());
    repeat (2) tick();
    chk("t4_fifth_held", 96'(ch_ready[0]), 96'h0);
    put(1, rnd_word()); put(2, rnd_word());
    tick();
    tick();
    chk("t4_ready0_back", 96'(ch_ready[0]), 96'h1);
    repeat (3) tick();

    // 5: back-to-back triples after a clean reset, then finish the 4x2 frame
    do_reset(2);
    max_run  = 0;
    fd_count = 0;
    start    = rv_count;
    feed_triples(6);
    repeat (8) tick();
    chk("t5_result_count", 96'(rv_count - start), 96'd6);
    chk("t5_run", 96'(max_run), 96'd6);
    feed_triples(3);
    repeat (8) tick();
    chk("t6_frame_done_count", 96'(fd_count), 96'd1);
    chk("t6_next_pos", 96'({last_col, last_row}), 96'h0);

    // 6b: reset with two results in flight
    feed_triples(2);
    tick();
    tick();
    start = rv_count;
    do_reset(1);
    repeat (10) tick();
    chk("inflight_dropped", 96'(rv_count - start), 96'h0);
    chk("post_reset_ready", 96'(ch_ready), 96'(3'b111));

    // Randomized traffic with varying per-channel arrival rates
    for (int blk = 0; blk < 6; blk++) begin
      for (int k = 0; k < 3; k++) pct[k] = int'($urandom_range(100, 20));
      repeat (300) begin
        for (int k = 0; k < 3; k++)
          if (!pending[k] && int'($urandom_range(99)) < pct[k]) put(k, rnd_word());
        tick();
      end
      if (blk == 3) do_reset(1);
    end
    pending = '0;
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
